mem_stream_reader: RTL and testbench

Read-side sequencer for the 16x8 inferred block RAM. On a start command it issues one-cycle-latency reads over a contiguous, wrapping address range. It presents the returned bytes on a valid/ready output stream, and a two-entry output buffer absorbs downstream backpressure without losing in-flight reads. It sits between the RAM's read port and any byte consumer (UART TX, LED display, checker).

---
 rtl/mem_stream_reader.sv | 155 +++++++++++++++
 tb/tb_mem_stream_reader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// ============================================================================
//  Module   : mem_stream_reader
//  Brief    : Read sequencer for a 1-cycle-latency RAM. It streams a wrapping
//             address range out through a two-entry valid/ready buffer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stream_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [2:0] c_buf_depth = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remaining;
    logic                r_inflight;
    logic [1:0]          r_occ;
    logic [DATA_W-1:0]   r_buf0;
    logic [DATA_W-1:0]   r_buf1;
    logic                r_done;

    logic                w_pop;
    logic                w_push;
    logic [2:0]          w_level;
    logic                w_issue;
    logic                w_accept;
    logic                w_zero_cmd;
    logic                w_drain_done;
    logic                w_done_nxt;
    logic [1:0]          w_wr_idx;

    assign w_pop      = out_valid & out_ready;
    assign w_push     = r_inflight;

    // Counting the in-flight read as occupied keeps a slot reserved for it,
    // so the buffer cannot overflow when the returned word lands.
    assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue    = (r_state == S_READ) && (r_remaining != '0) && (w_level < c_buf_depth);

    assign w_accept     = (r_state == S_IDLE) && start && (length != '0);
    assign w_zero_cmd   = (r_state == S_IDLE) && start && (length == '0);
    assign w_drain_done = (r_state == S_DRAIN) && w_pop && (r_occ == 2'd1) && !r_inflight;

    // Tail slot for an incoming word, after accounting for this cycle's pop.
    assign w_wr_idx   = r_occ - {1'b0, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_READ;
                end
                w_done_nxt = w_zero_cmd;
            end
            S_READ: begin
                if (w_issue && (r_remaining == {{ADDR_W{1'b0}}, 1'b1})) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_accept) begin
                r_addr      <= start_addr;
                r_remaining <= length;
            end else if (w_issue) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    // Two-entry buffer: r_buf0 is always the head, so a pop shifts r_buf1 down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_buf0 <= r_buf1;
            end
            if (w_push) begin
                if (w_wr_idx == 2'd0) begin
                    r_buf0 <= mem_r_data;
                end else begin
                    r_buf1 <= mem_r_data;
                end
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign mem_r_en   = w_issue;
    assign mem_r_addr = r_addr;
    assign out_valid  = (r_occ != 2'd0);
    assign out_data   = r_buf0;

endmodule

`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
// ============================================================================
//  Module   : tb_mem_stream_reader
//  Brief    : Directed bench for mem_stream_reader with a 16x8 RAM model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] length;
    logic       busy;
    logic       done;
    logic       mem_r_en;
    logic [3:0] mem_r_addr;
    logic [7:0] mem_r_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    logic [7:0] ram [16];
    int         n_total = 0;
    int         n_bad   = 0;

    always #5 clk = ~clk;

    mem_stream_reader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .mem_r_en   (mem_r_en),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always @(posedge clk) begin
        if (mem_r_en) mem_r_data <= ram[mem_r_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one command starting in the current cycle (T) and checks the stream
    // cycle by cycle against a small occupancy model. Returns key cycle indices.
    task automatic run_cmd(input string tag, input logic [3:0] sa, input logic [4:0] len,
                           input logic [31:0] pat, input bit inject,
                           output int first_en, output int first_valid,
                           output int last_word, output int done_cyc);
        int   nw, ni, occ_m;
        bit   inf_m, pop, stalled, got_done;
        logic [7:0] held;
        nw = 0; ni = 0; occ_m = 0; inf_m = 0; stalled = 0; got_done = 0; held = '0;
        first_en = -1; first_valid = -1; last_word = -1; done_cyc = -1;
        start = 1'b1; start_addr = sa; length = len; out_ready = pat[0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 300 && !got_done; cyc++) begin
            out_ready = pat[cyc % 32];
            start = inject && (cyc == 4);
            start_addr = 4'd9; length = 5'd3;
            #1;
            pop = out_valid & out_ready;
            check_val({tag, " valid_vs_occ"}, {31'b0, out_valid}, {31'b0, occ_m != 0});
            check_val({tag, " busy"}, {31'b0, busy}, {31'b0, !done});
            if (stalled && out_valid)
                check_val({tag, " stall_hold"}, {24'b0, out_data}, {24'b0, held});
            if (mem_r_en) begin
                check_val({tag, " issue_rule"}, {31'b0, (occ_m + int'(inf_m) - int'(pop)) < 2}, 32'd1);
                check_val({tag, " rd_addr"}, {28'b0, mem_r_addr}, {28'b0, 4'(sa + ni)});
                if (first_en < 0) first_en = cyc;
                ni++;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (pop) begin
                check_val({tag, " word"}, {24'b0, out_data}, {24'b0, 8'hA0 + 8'(4'(sa + nw))});
                nw++;
                last_word = cyc;
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
            occ_m   = occ_m + int'(inf_m) - int'(pop);
            inf_m   = mem_r_en;
            stalled = out_valid & !out_ready;
            held    = out_data;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_val({tag, " done_seen"}, {31'b0, got_done}, 32'd1);
        check_val({tag, " word_count"}, nw, {27'b0, len});
        check_val({tag, " issue_count"}, ni, {27'b0, len});
        #1;
        check_val({tag, " done_one_cycle"}, {31'b0, done}, 32'd0);
        check_val({tag, " idle_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int fe, fv, lw, dc;
        logic [31:0] pat;
        for (int i = 0; i < 16; i++) ram[i] = 8'hA0 + 8'(i);
        mem_r_data = '0;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst busy",   {31'b0, busy}, 32'd0);
        check_val("rst done",   {31'b0, done}, 32'd0);
        check_val("rst r_en",   {31'b0, mem_r_en}, 32'd0);
        check_val("rst r_addr", {28'b0, mem_r_addr}, 32'd0);
        check_val("rst valid",  {31'b0, out_valid}, 32'd0);
        check_val("rst data",   {24'b0, out_data}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full sweep with the consumer always ready.
        run_cmd("full", 4'd0, 5'd16, 32'hFFFF_FFFF, 0, fe, fv, lw, dc);
        check_val("full first_en",    fe, 32'd1);
        check_val("full first_valid", fv, 32'd3);
        check_val("full last_word",   lw, 32'd18);
        check_val("full done_cyc",    dc, 32'd19);

        // Address wrap 14,15,0,1.
        run_cmd("wrap", 4'd14, 5'd4, 32'hFFFF_FFFF, 0, fe, fv, lw, dc);
        check_val("wrap done_cyc", dc, 32'd7);

        // Backpressure pattern plus a stray start mid-command.
        pat = 32'hC3A5_1E09;
        run_cmd("bp", 4'd3, 5'd8, pat, 1, fe, fv, lw, dc);

        // Zero-length command.
        start = 1'b1; start_addr = 4'd7; length = 5'd0;
        #1;
        check_val("zero busy_T", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check_val("zero done",  {31'b0, done}, 32'd1);
        check_val("zero busy",  {31'b0, busy}, 32'd0);
        check_val("zero r_en",  {31'b0, mem_r_en}, 32'd0);
        check_val("zero valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check_val("zero done_end", {31'b0, done}, 32'd0);
        check_val("zero r_en2",    {31'b0, mem_r_en}, 32'd0);

        // Asynchronous reset mid-stream, after three words have been delivered.
        out_ready = 1'b1;
        start = 1'b1; start_addr = 4'd0; length = 5'd10;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 40 && seen < 3; c++) begin
                if (out_valid && out_ready) seen++;
                @(posedge clk); #1;
            end
            check_val("arst words_before", seen, 32'd3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst busy",   {31'b0, busy}, 32'd0);
        check_val("arst done",   {31'b0, done}, 32'd0);
        check_val("arst r_en",   {31'b0, mem_r_en}, 32'd0);
        check_val("arst r_addr", {28'b0, mem_r_addr}, 32'd0);
        check_val("arst valid",  {31'b0, out_valid}, 32'd0);
        check_val("arst data",   {24'b0, out_data}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check_val("post_rst valid", {31'b0, out_valid}, 32'd0);
            check_val("post_rst r_en",  {31'b0, mem_r_en}, 32'd0);
        end
        run_cmd("after_rst", 4'd5, 5'd2, 32'hFFFF_FFFF, 0, fe, fv, lw, dc);
        check_val("after_rst done_cyc", dc, 32'd5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
